// File: rtl/spi_shifter.sv
// SPI mode-0 byte shifter: IDLE -> SHIFT (8 sck_rise/sck_fall pairs) -> DONE; MSB-first unless SPI_LSB_FIRST_EN.
// Latency: accepted start to done = 1 + SCK span + 1 cycles; all outputs registered.
// Backpressure: start is only sampled in IDLE; there is no request queue.
module spi_shifter (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] tx_data,
    input  logic       sck_rise,
    input  logic       sck_fall,
    input  logic       miso,
    output logic       sck_en,
    output logic       mosi,
    output logic       cs_n,
    output logic       busy,
    output logic       done,
    output logic [7:0] rx_data
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t     state, state_nxt;
    logic [7:0] tx_sr, tx_sr_nxt;
    logic [7:0] rx_sr, rx_sr_nxt;
    logic [7:0] rx_data_nxt;
    logic [3:0] cnt, cnt_nxt;
    logic       sck_en_nxt, mosi_nxt, cs_n_nxt, busy_nxt, done_nxt;

    logic       tx_first;
    logic       tx_next;
    logic [7:0] tx_shift;
    logic [7:0] rx_shift;

`ifdef SPI_LSB_FIRST_EN
    // LSB-first: tx leaves from bit 0, rx enters at bit 7 and moves down
    assign tx_first = tx_data[0];
    assign tx_next  = tx_sr[1];
    assign tx_shift = {1'b0, tx_sr[7:1]};
    assign rx_shift = {miso, rx_sr[7:1]};
`else
    assign tx_first = tx_data[7];
    assign tx_next  = tx_sr[6];
    assign tx_shift = {tx_sr[6:0], 1'b0};
    assign rx_shift = {rx_sr[6:0], miso};
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            tx_sr   <= 8'h00;
            rx_sr   <= 8'h00;
            rx_data <= 8'h00;
            cnt     <= 4'd0;
            sck_en  <= 1'b0;
            mosi    <= 1'b0;
            cs_n    <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_nxt;
            tx_sr   <= tx_sr_nxt;
            rx_sr   <= rx_sr_nxt;
            rx_data <= rx_data_nxt;
            cnt     <= cnt_nxt;
            sck_en  <= sck_en_nxt;
            mosi    <= mosi_nxt;
            cs_n    <= cs_n_nxt;
            busy    <= busy_nxt;
            done    <= done_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        tx_sr_nxt   = tx_sr;
        rx_sr_nxt   = rx_sr;
        rx_data_nxt = rx_data;
        cnt_nxt     = cnt;
        sck_en_nxt  = sck_en;
        mosi_nxt    = mosi;
        cs_n_nxt    = cs_n;
        busy_nxt    = busy;
        done_nxt    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    tx_sr_nxt  = tx_data;
                    rx_sr_nxt  = 8'h00;
                    mosi_nxt   = tx_first;
                    cs_n_nxt   = 1'b0;
                    sck_en_nxt = 1'b1;
                    busy_nxt   = 1'b1;
                    cnt_nxt    = 4'd0;
                    state_nxt  = SHIFT;
                end
            end
            SHIFT: begin
                // a rise wins over a coincident fall
                if (sck_rise) begin
                    rx_sr_nxt = rx_shift;
                    cnt_nxt   = cnt + 4'd1;
                end else if (sck_fall) begin
                    if (cnt == 4'd8) begin
                        state_nxt = DONE;
                    end else begin
                        tx_sr_nxt = tx_shift;
                        mosi_nxt  = tx_next;
                    end
                end
            end
            DONE: begin
                done_nxt    = 1'b1;
                rx_data_nxt = rx_sr;
                busy_nxt    = 1'b0;
                sck_en_nxt  = 1'b0;
                cs_n_nxt    = 1'b1;
                state_nxt   = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule
